om_interval_coalescer: RTL

Upstream stage of the overflow-interval store: observes the stream of stores flagged as overflowing by the detection logic and coalesces contiguous or overlapping byte ranges into closed intervals [first, last]. Each closed interval is emitted as a one-cycle write (first, last, is_big) directly into the circular overflow buffer. The buffer accepts a write every cycle, so there is no backpressure.

---
 rtl/om_pkg.sv | 26 ++
 rtl/om_interval_coalescer.sv | 138 +++++++++++++
 2 files changed

// File: rtl/om_pkg.sv
// Shared types for the overflow-interval path: FSM states, store size codes
// and the address type used by detection, coalescer and circular buffer.
package om_pkg;

    typedef logic [31:0] om_addr_t;

    typedef enum logic [0:0] {
        OM_IDLE = 1'b0,
        OM_OPEN = 1'b1
    } om_state_e;

    localparam logic [1:0] OM_SIZE_BYTE = 2'd0;
    localparam logic [1:0] OM_SIZE_HALF = 2'd1;
    localparam logic [1:0] OM_SIZE_WORD = 2'd2;
    localparam logic [1:0] OM_SIZE_RSVD = 2'd3;

    // The reserved encoding is treated as a word access.
    function automatic logic [2:0] om_bytes(input logic [1:0] size);
        case (size)
            OM_SIZE_BYTE: om_bytes = 3'd1;
            OM_SIZE_HALF: om_bytes = 3'd2;
            default:      om_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/om_interval_coalescer.sv
// Coalesces overflowing store byte ranges into closed intervals and emits each
// closed interval as a one-cycle write into the circular overflow buffer.
module om_interval_coalescer
    import om_pkg::*;
#(
    parameter int unsigned BIG_THRESHOLD = 64,
    parameter int unsigned IDLE_TIMEOUT  = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clear_i,
    input  logic       flush_i,
    input  logic       valid_i,
    input  om_addr_t   addr_i,
    input  logic [1:0] size_i,
    output logic       en_write_o,
    output om_addr_t   addr_first_o,
    output om_addr_t   addr_last_o,
    output logic       is_big_o,
    output logic       busy_o
);

    localparam int unsigned CW = (IDLE_TIMEOUT > 2) ? $clog2(IDLE_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_TIMEOUT - 1);

    om_state_e     state_q, state_d;
    om_addr_t      first_q, first_d;
    om_addr_t      last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic          en_q;
    om_addr_t      out_first_q, out_last_q;
    logic          big_q;

    logic [32:0]   e_wide;
    om_addr_t      e;
    logic          mergeable, closing, emit, emit_big;
    om_addr_t      nf, nl, ef, el;
    logic [32:0]   length;

    always_comb begin
        // End address clamps at the top of the address space instead of wrapping.
        e_wide    = {1'b0, addr_i} + 33'(om_bytes(size_i)) - 33'd1;
        e         = e_wide[32] ? 32'hFFFF_FFFF : e_wide[31:0];
        mergeable = ({1'b0, addr_i} <= ({1'b0, last_q} + 33'd1)) &&
                    (({1'b0, e} + 33'd1) >= {1'b0, first_q});
        closing   = flush_i | pend_q;

        if (state_q == OM_IDLE) begin
            nf = addr_i;
            nl = e;
        end else begin
            nf = (addr_i < first_q) ? addr_i : first_q;
            nl = (e > last_q) ? e : last_q;
        end

        state_d = state_q;
        first_d = first_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        emit    = 1'b0;
        ef      = first_q;
        el      = last_q;

        if (clear_i) begin
            state_d = OM_IDLE;
            pend_d  = 1'b0;
            cnt_d   = '0;
        end else if (valid_i) begin
            cnt_d = '0;
            if (state_q == OM_IDLE || mergeable) begin
                first_d = nf;
                last_d  = nl;
                if (closing) begin
                    emit    = 1'b1;
                    ef      = nf;
                    el      = nl;
                    state_d = OM_IDLE;
                    pend_d  = 1'b0;
                end else begin
                    state_d = OM_OPEN;
                end
            end else begin
                // Disjoint store: retire the old interval, the new one may still owe a flush.
                emit    = 1'b1;
                first_d = addr_i;
                last_d  = e;
                pend_d  = closing;
            end
        end else if (state_q == OM_OPEN) begin
            if (closing || (cnt_q + CW'(1)) == CNT_LAST) begin
                emit    = 1'b1;
                state_d = OM_IDLE;
                pend_d  = 1'b0;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        length   = {1'b0, el} - {1'b0, ef} + 33'd1;
        emit_big = length > 33'(BIG_THRESHOLD);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= OM_IDLE;
            first_q     <= '0;
            last_q      <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            en_q        <= 1'b0;
            out_first_q <= '0;
            out_last_q  <= '0;
            big_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            en_q    <= emit;
            if (emit) begin
                out_first_q <= ef;
                out_last_q  <= el;
                big_q       <= emit_big;
            end
        end
    end

    assign en_write_o   = en_q;
    assign addr_first_o = out_first_q;
    assign addr_last_o  = out_last_q;
    assign is_big_o     = big_q;
    assign busy_o       = (state_q == OM_OPEN);

endmodule
